// File: rtl/scan_dpram.sv
// Dual-port RAM with synchronised switch-driven writes, a self-scanning read port,
// and a post-reset zero-fill that clears the array before reads become valid.
module scan_dpram #(
   parameter int DW     = 8,
   parameter int AW     = 5,
   parameter int TICK   = 25000000,
   parameter int SYNC   = 2,
   parameter int BYPASS = 1
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          wr_en_in,
   input  logic [AW-1:0] wr_addr_in,
   input  logic [DW-1:0] wr_data_in,
   input  logic          scan_en,
   output logic          wr_en_q,
   output logic [AW-1:0] wr_addr_q,
   output logic [DW-1:0] wr_data_q,
   output logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          busy
);

   localparam int DEPTH = 1 << AW;
   localparam int CW    = (TICK > 1) ? $clog2(TICK) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t        state;
   logic [AW-1:0] fill;
   logic [CW-1:0] prescale;
   logic          tick;
   logic          collide;

   logic          en_sync   [SYNC];
   logic [AW-1:0] addr_sync [SYNC];
   logic [DW-1:0] data_sync [SYNC];

   logic [DW-1:0] mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   // Switch inputs are asynchronous; reset flushes the whole chain to zero.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < SYNC; i++) begin
            en_sync[i]   <= 1'b0;
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
         end
      end else begin
         en_sync[0]   <= wr_en_in;
         addr_sync[0] <= wr_addr_in;
         data_sync[0] <= wr_data_in;
         for (int i = 1; i < SYNC; i++) begin
            en_sync[i]   <= en_sync[i-1];
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
      end
   end

   assign wr_en_q   = en_sync[SYNC-1];
   assign wr_addr_q = addr_sync[SYNC-1];
   assign wr_data_q = data_sync[SYNC-1];

   // The write port belongs to the zero-fill during INIT and to the user in RUN.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr_q;
      mem_wdata = wr_data_q;
      if (!Reset) begin
         if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = fill;
            mem_wdata = '0;
         end else if (wr_en_q) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign tick    = (prescale == CW'(TICK - 1));
   assign collide = wr_en_q && (wr_addr_q == rd_addr);

   // Sequencer, scan prescaler and registered read; the read uses the
   // pre-increment address even when a tick lands in the same cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= INIT;
         fill     <= '0;
         prescale <= '0;
         rd_addr  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               fill <= fill + AW'(1);
               if (fill == '1) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               if (scan_en) begin
                  if (tick) begin
                     prescale <= '0;
                     rd_addr  <= rd_addr + AW'(1);
                  end else begin
                     prescale <= prescale + CW'(1);
                  end
               end
               rd_valid <= 1'b1;
               if ((BYPASS != 0) && collide) begin
                  rd_data <= wr_data_q;
               end else begin
                  rd_data <= mem[rd_addr];
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_scan_dpram.sv
// Bench for scan_dpram: one new-data and one old-data instance on shared inputs,
// checked every cycle against an abstract model plus directed timing checks.
module tb_scan_dpram;

   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int TICK  = 4;
   localparam int SYNC  = 2;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } samp_t;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          wr_en_in;
   logic [AW-1:0] wr_addr_in;
   logic [DW-1:0] wr_data_in;
   logic          scan_en;

   logic          wr_en_q_b, wr_en_q_o;
   logic [AW-1:0] wr_addr_q_b, wr_addr_q_o;
   logic [DW-1:0] wr_data_q_b, wr_data_q_o;
   logic [AW-1:0] rd_addr_b, rd_addr_o;
   logic [DW-1:0] rd_data_b, rd_data_o;
   logic          rd_valid_b, rd_valid_o;
   logic          busy_b, busy_o;

   int compared;
   int mismatched;
   int n;

   bit            live = 1'b0;
   int            k_edges;
   int            scan_steps;
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] m_rd_b, m_rd_o;
   samp_t         pipe [$];

   always #5 Clock = ~Clock;

   scan_dpram #(.DW(DW), .AW(AW), .TICK(TICK), .SYNC(SYNC), .BYPASS(1)) dut_b (
      .Clock(Clock), .Reset(Reset), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
      .wr_data_in(wr_data_in), .scan_en(scan_en), .wr_en_q(wr_en_q_b),
      .wr_addr_q(wr_addr_q_b), .wr_data_q(wr_data_q_b), .rd_addr(rd_addr_b),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b));

   scan_dpram #(.DW(DW), .AW(AW), .TICK(TICK), .SYNC(SYNC), .BYPASS(0)) dut_o (
      .Clock(Clock), .Reset(Reset), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
      .wr_data_in(wr_data_in), .scan_en(scan_en), .wr_en_q(wr_en_q_o),
      .wr_addr_q(wr_addr_q_o), .wr_data_q(wr_data_q_o), .rd_addr(rd_addr_o),
      .rd_data(rd_data_o), .rd_valid(rd_valid_o), .busy(busy_o));

   // Scan address is simply the number of completed scan periods, modulo depth.
   function automatic int model_addr();
      return (scan_steps / TICK) % DEPTH;
   endfunction

   // Reference model: delay line for the synchroniser, edge count for fill/busy.
   always @(posedge Clock) begin
      samp_t cur;
      samp_t smp;
      int    ra;
      if (Reset) begin
         live       = 1'b1;
         k_edges    = 0;
         scan_steps = 0;
         m_rd_b     = '0;
         m_rd_o     = '0;
         pipe.delete();
         for (int i = 0; i < SYNC; i++) pipe.push_back('0);
      end else if (live) begin
         cur = pipe[0];
         ra  = model_addr();
         if (k_edges < DEPTH) begin
            model_mem[k_edges] = '0;
         end else begin
            m_rd_o = model_mem[ra];
            m_rd_b = (cur.en && int'(cur.addr) == ra) ? cur.data : model_mem[ra];
            if (cur.en) model_mem[cur.addr] = cur.data;
            if (scan_en) scan_steps++;
         end
         k_edges++;
         smp.en   = wr_en_in;
         smp.addr = wr_addr_in;
         smp.data = wr_data_in;
         pipe.push_back(smp);
         void'(pipe.pop_front());
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compareAll();
      if (live) begin
         checkOutput("wr_en_q",    32'(wr_en_q_b),   32'(pipe[0].en));
         checkOutput("wr_addr_q",  32'(wr_addr_q_b), 32'(pipe[0].addr));
         checkOutput("wr_data_q",  32'(wr_data_q_b), 32'(pipe[0].data));
         checkOutput("rd_addr_b",  32'(rd_addr_b),   32'(model_addr()));
         checkOutput("rd_addr_o",  32'(rd_addr_o),   32'(model_addr()));
         checkOutput("rd_data_b",  32'(rd_data_b),   32'(m_rd_b));
         checkOutput("rd_data_o",  32'(rd_data_o),   32'(m_rd_o));
         checkOutput("rd_valid_b", 32'(rd_valid_b),  32'(k_edges > DEPTH));
         checkOutput("rd_valid_o", 32'(rd_valid_o),  32'(k_edges > DEPTH));
         checkOutput("busy_b",     32'(busy_b),      32'(k_edges < DEPTH));
         checkOutput("busy_o",     32'(busy_o),      32'(k_edges < DEPTH));
         checkOutput("wr_en_q_o",  32'(wr_en_q_o),   32'(pipe[0].en));
      end
   endtask

   // Drives inputs for the next rising edge, then checks the state after it.
   task automatic applyStimulus(input logic rst, input logic en, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic se);
      Reset      = rst;
      wr_en_in   = en;
      wr_addr_in = addr;
      wr_data_in = data;
      scan_en    = se;
      @(negedge Clock);
      compareAll();
   endtask

   // Stops on the cycle a new scan period has just begun at the target address.
   task automatic scanTo(input int target);
      int g = 0;
      while (model_addr() == target && g < 400) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         g++;
      end
      while (model_addr() != target && g < 400) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         g++;
      end
      checkOutput($sformatf("reach_addr_%0d", target), 32'(rd_addr_b), 32'(target));
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      repeat (3) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
         n++;
      end while (busy_b && n < 100);
      checkOutput("busy_cycles", 32'(n), 32);
      checkOutput("rd_valid_low", 32'(rd_valid_b), 0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput("rd_valid_rise", 32'(rd_valid_b), 1);

      repeat (DEPTH * TICK + 4) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);

      applyStimulus(1'b0, 1'b1, 5'd3, 8'hA5, 1'b1);
      checkOutput("wr_data_q_early", 32'(wr_data_q_b), 0);
      applyStimulus(1'b0, 1'b1, 5'd3, 8'hA5, 1'b1);
      checkOutput("wr_data_q_sync", 32'(wr_data_q_b), 32'hA5);
      applyStimulus(1'b0, 1'b1, 5'd3, 8'hA5, 1'b1);
      scanTo(3);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("read_a5_b", 32'(rd_data_b), 32'hA5);
      checkOutput("read_a5_o", 32'(rd_data_o), 32'hA5);

      scanTo(31);
      n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         n++;
      end while (rd_addr_b == 5'd31 && n < 20);
      checkOutput("wrap_cycles", 32'(n), 4);
      checkOutput("wrap_addr", 32'(rd_addr_b), 0);

      scanTo(7);
      applyStimulus(1'b0, 1'b1, 5'd7, 8'h11, 1'b0);
      repeat (4) applyStimulus(1'b0, 1'b0, 5'd7, '0, 1'b0);
      checkOutput("old_11_b", 32'(rd_data_b), 32'h11);
      checkOutput("old_11_o", 32'(rd_data_o), 32'h11);
      applyStimulus(1'b0, 1'b1, 5'd7, 8'h3C, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd7, '0, 1'b0);
      applyStimulus(1'b0, 1'b0, 5'd7, '0, 1'b0);
      checkOutput("coll_new_b", 32'(rd_data_b), 32'h3C);
      checkOutput("coll_old_o", 32'(rd_data_o), 32'h11);
      applyStimulus(1'b0, 1'b0, 5'd7, '0, 1'b0);
      checkOutput("coll_late_o", 32'(rd_data_o), 32'h3C);
      applyStimulus(1'b0, 1'b1, 5'd7, 8'h42, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 5'd7, '0, 1'b0);
      checkOutput("freeze_42_b", 32'(rd_data_b), 32'h42);
      checkOutput("freeze_42_o", 32'(rd_data_o), 32'h42);
      checkOutput("freeze_addr", 32'(rd_addr_b), 7);
      n = 0;
      do begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
         n++;
      end while (rd_addr_b == 5'd7 && n < 20);
      checkOutput("resume_cycles", 32'(n), 4);
      checkOutput("resume_addr", 32'(rd_addr_b), 8);

      for (int i = 0; i < 500; i++) begin
         applyStimulus(i == 250 || i == 251,
                       $urandom_range(0, 3) == 0,
                       AW'($urandom_range(0, DEPTH - 1)),
                       DW'($urandom_range(0, 255)),
                       $urandom_range(0, 3) != 0);
      end

      repeat (2) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b1, 5'd5, 8'hFF, 1'b0);
      applyStimulus(1'b1, 1'b1, 5'd5, 8'hFF, 1'b0);
      n = 0;
      do begin
         applyStimulus(1'b0, n < 20, 5'd5, 8'hFF, 1'b0);
         n++;
      end while (busy_b && n < 100);
      checkOutput("busy_after_midinit", 32'(n), 32);
      scanTo(5);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("init_guard_b", 32'(rd_data_b), 0);
      checkOutput("init_guard_o", 32'(rd_data_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
